// File: rtl/decision_level_controller.sv
// Decision-level controller for a DPLL-style SAT solver: picks the lowest
// unassigned literal, tracks decision levels on a stack, and drives assign /
// unassign strobes toward the literal update stage. Strobes and status outputs
// are registered from the next state, so each one lines up with the state it
// belongs to.
module decision_level_controller #(
  parameter int unsigned WIDTH        = 9,
  parameter int unsigned MAX_LITERALS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MAX_LITERALS-1:0] literal_active_mask,
  input  logic [MAX_LITERALS-1:0] literal_assigned_in,
  input  logic                    propagate_done,
  input  logic                    conflict,
  output logic [WIDTH-2:0]        choosen_lit,
  output logic                    choosen_lit_bool_val,
  output logic [WIDTH-1:0]        current_level,
  output logic                    update_based_on_choosen_lit,
  output logic                    update_based_on_re_update,
  output logic                    busy,
  output logic                    sat,
  output logic                    unsat
);

  localparam int unsigned LIT_W = WIDTH - 1;
  localparam int unsigned SP_W  = (MAX_LITERALS > 1) ? $clog2(MAX_LITERALS) : 1;

  typedef enum logic [2:0] {
    IDLE, PICK, ASSIGN, WAIT, BACKTRACK, DONE_SAT, DONE_UNSAT
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        level_q, level_d;
  logic [LIT_W-1:0]        stack_idx_q [MAX_LITERALS];
  logic [LIT_W-1:0]        stack_idx_d [MAX_LITERALS];
  logic [MAX_LITERALS-1:0] stack_flip_q, stack_flip_d;
  logic [LIT_W-1:0]        lit_q, lit_d;
  logic                    bool_q, bool_d;
  logic [WIDTH-1:0]        cur_lvl_q, cur_lvl_d;
  logic                    upd_q, upd_d;
  logic                    re_q, re_d;
  logic                    busy_q, busy_d;
  logic                    sat_q, sat_d;
  logic                    unsat_q, unsat_d;

  logic [MAX_LITERALS-1:0] unassigned;
  logic [LIT_W-1:0]        pick_idx;
  logic [SP_W-1:0]         top_q_ptr;
  logic [SP_W-1:0]         top_d_ptr;

  assign unassigned = literal_active_mask & ~literal_assigned_in;
  assign top_q_ptr  = SP_W'(level_q - WIDTH'(1));

  // Lowest-index unassigned literal (descending scan, last hit wins).
  always_comb begin
    pick_idx = '0;
    for (int i = int'(MAX_LITERALS) - 1; i >= 0; i--) begin
      if (unassigned[i]) pick_idx = LIT_W'(i);
    end
  end

  // Next-state, stack update and registered-output computation.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    stack_idx_d  = stack_idx_q;
    stack_flip_d = stack_flip_q;
    lit_d        = lit_q;
    bool_d       = bool_q;
    cur_lvl_d    = cur_lvl_q;
    upd_d        = 1'b0;
    re_d         = 1'b0;
    top_d_ptr    = '0;

    unique case (state_q)
      IDLE, DONE_SAT, DONE_UNSAT: begin
        if (start) begin
          level_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (propagate_done) begin
          if (!conflict)             state_d = PICK;
          else if (level_q == '0)    state_d = DONE_UNSAT;
          else                       state_d = BACKTRACK;
        end
      end
      PICK: begin
        if (unassigned == '0) begin
          state_d = DONE_SAT;
        end else begin
          // Each push consumes a distinct unassigned literal, so the full
          // case only guards the level from wrapping.
          if (level_q != WIDTH'(MAX_LITERALS)) begin
            stack_idx_d[SP_W'(level_q)]  = pick_idx;
            stack_flip_d[SP_W'(level_q)] = 1'b0;
            level_d                      = level_q + WIDTH'(1);
          end
          state_d = ASSIGN;
        end
      end
      ASSIGN: begin
        state_d = WAIT;
      end
      BACKTRACK: begin
        if (level_q == '0) begin
          state_d = DONE_UNSAT;
        end else if (!stack_flip_q[top_q_ptr]) begin
          stack_flip_d[top_q_ptr] = 1'b1;
          state_d                 = ASSIGN;
        end else begin
          level_d = level_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    top_d_ptr = SP_W'(level_d - WIDTH'(1));
    if (state_d == ASSIGN) begin
      upd_d     = 1'b1;
      lit_d     = stack_idx_d[top_d_ptr];
      bool_d    = ~stack_flip_d[top_d_ptr];
      cur_lvl_d = level_d;
    end else if (state_d == BACKTRACK && level_d != '0) begin
      re_d      = 1'b1;
      cur_lvl_d = level_d;
    end

    busy_d  = !(state_d inside {IDLE, DONE_SAT, DONE_UNSAT});
    sat_d   = (state_d == DONE_SAT);
    unsat_d = (state_d == DONE_UNSAT);
  end

  // State, stack and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= '0;
      stack_flip_q <= '0;
      for (int i = 0; i < int'(MAX_LITERALS); i++) stack_idx_q[i] <= '0;
      lit_q        <= '0;
      bool_q       <= 1'b0;
      cur_lvl_q    <= '0;
      upd_q        <= 1'b0;
      re_q         <= 1'b0;
      busy_q       <= 1'b0;
      sat_q        <= 1'b0;
      unsat_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      stack_flip_q <= stack_flip_d;
      stack_idx_q  <= stack_idx_d;
      lit_q        <= lit_d;
      bool_q       <= bool_d;
      cur_lvl_q    <= cur_lvl_d;
      upd_q        <= upd_d;
      re_q         <= re_d;
      busy_q       <= busy_d;
      sat_q        <= sat_d;
      unsat_q      <= unsat_d;
    end
  end

  assign choosen_lit                 = lit_q;
  assign choosen_lit_bool_val        = bool_q;
  assign current_level               = cur_lvl_q;
  assign update_based_on_choosen_lit = upd_q;
  assign update_based_on_re_update   = re_q;
  assign busy                        = busy_q;
  assign sat                         = sat_q;
  assign unsat                       = unsat_q;

endmodule
